alu_mc: RTL and testbench

Multi-cycle 32-bit execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and returns a registered result through a start/done handshake. AND, OR, ADD, SUB, SLT, address add (LW/SW) and LUI complete in one cycle. MUL runs as an iterative shift-add over 32 cycles. The block sits in the EX stage between the register-file/immediate operand muxes and the writeback/memory-address path.

---
 rtl/alu_mc.sv | 213 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage execute unit with start/done handshake and registered results.
// Optional macro ALU_MUL_EN compiles in the 32-iteration shift-add multiplier (code 1000).
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_LW  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_LUI = 4'b1011;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state_r, state_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] sum_s, diff_s, res_s;
    logic             ovf_s, ill_s;
    logic             accept_s;
    logic             done_r, zero_r, ovf_r, ill_r;
    logic [WIDTH-1:0] result_r;

`ifdef ALU_MUL_EN
    logic [5:0]       cnt_r;
    logic [WIDTH-1:0] acc_r, mcand_r, mplier_r;
    logic             busy_r;
`endif

    assign accept_s = (state_r == IDLE) && start_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
`ifdef ALU_MUL_EN
                    if (ALUCtrl_i == OP_MUL) begin
                        state_s = MUL_RUN;
                    end else begin
                        state_s = DONE;
                    end
`else
                    state_s = DONE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = MUL_RUN;
                end
            end
`endif
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand capture at the accepting edge; later input changes are ignored
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_r <= 4'b0000;
            a_r  <= '0;
            b_r  <= '0;
        end else if (accept_s) begin
            op_r <= ALUCtrl_i;
            a_r  <= src1_i;
            b_r  <= src2_i;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: one multiplier bit per MUL_RUN cycle, no early exit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r    <= 6'd0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (accept_s) begin
            cnt_r    <= 6'd0;
            acc_r    <= '0;
            mcand_r  <= src1_i;
            mplier_r <= src2_i;
        end else if (state_r == MUL_RUN) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= (cnt_r == CNT_LAST) ? 6'd0 : cnt_r + 6'd1;
        end else begin
            cnt_r    <= cnt_r;
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
        end
    end

    // busy follows the registered state so it spans exactly the iteration cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s == MUL_RUN);
        end
    end

    assign busy_o = busy_r;
`else
    assign busy_o = 1'b0;
`endif

    // Result datapath evaluated from the captured operation
    always_comb begin
        sum_s  = a_r + b_r;
        diff_s = a_r - b_r;
        res_s  = '0;
        ovf_s  = 1'b0;
        ill_s  = 1'b0;
        case (op_r)
            OP_AND: res_s = a_r & b_r;
            OP_OR:  res_s = a_r | b_r;
            OP_ADD, OP_LW, OP_SW: begin
                res_s = sum_s;
                ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s;
                ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SLT: res_s = ($signed(a_r) < $signed(b_r)) ? WIDTH'(1) : '0;
            OP_LUI: res_s = WIDTH'({b_r[15:0], 16'h0000});
`ifdef ALU_MUL_EN
            OP_MUL: res_s = acc_r;
`endif
            default: ill_s = 1'b1;
        endcase
    end

    // Output registers: load only in the DONE cycle, hold otherwise
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
            ovf_r    <= 1'b0;
            ill_r    <= 1'b0;
        end else if (state_r == DONE) begin
            done_r   <= 1'b1;
            result_r <= res_s;
            zero_r   <= (res_s == '0);
            ovf_r    <= ovf_s;
            ill_r    <= ill_s;
        end else begin
            done_r   <= 1'b0;
            result_r <= result_r;
            zero_r   <= zero_r;
            ovf_r    <= ovf_r;
            ill_r    <= ill_r;
        end
    end

    assign done_o     = done_r;
    assign result_o   = result_r;
    assign zero_o     = zero_r;
    assign overflow_o = ovf_r;
    assign illegal_o  = ill_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized scoreboard bench for alu_mc; expected responses come from an
// arithmetic reference model and are compared by an independent monitor on done_o.
module tb_alu_mc;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] src1_i, src2_i;
    logic        busy_o, done_o, zero_o, overflow_o, illegal_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    alu_mc #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ALUCtrl_i(ALUCtrl_i),
        .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer arithmetic, overflow = truncated result differs from true value
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, t;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        e.res = 32'h0; e.ovf = 1'b0; e.ill = 1'b0; e.due = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010, 4'b1001, 4'b1010: begin
                t = sa + sb; e.res = 32'(t);
                e.ovf = (t != longint'($signed(e.res)));
            end
            4'b0110: begin
                t = sa - sb; e.res = 32'(t);
                e.ovf = (t != longint'($signed(e.res)));
            end
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1011: e.res = {b[15:0], 16'h0000};
`ifdef ALU_MUL_EN
            4'b1000: begin
                p = {32'h0, a} * {32'h0, b};
                e.res = p[31:0];
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int lat_of(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return (op == 4'b1000) ? 33 : 1;
`else
        return 1;
`endif
    endfunction

    // Issue one request, push its expectation, then wait (bounded) for done_o
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
        exp_t e;
        int   busy_cnt;
        bit   got;
        e = model(op, a, b);
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = op; src1_i = a; src2_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; ALUCtrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom;
        e.due = cyc + lat_of(op);
        sb_q.push_back(e);
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                got = 1'b1;
            end else begin
                if (poke && i == 5) begin
                    start_i = 1'b1; ALUCtrl_i = 4'b0010;
                end else begin
                    start_i = 1'b0;
                end
                @(negedge clk_i);
            end
        end
        start_i = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", busy_cnt, (lat_of(op) == 33) ? 32'd32 : 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents done_o
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i === 1'b1) begin
            if (done_o) begin
                chk("done_gap", 32'(prev_done), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=done expected=no_done (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result_o, e.res);
                    chk("zero", 32'(zero_o), 32'(e.res == 32'h0));
                    chk("overflow", 32'(overflow_o), 32'(e.ovf));
                    chk("illegal", 32'(illegal_o), 32'(e.ill));
                    chk("latency", cyc, e.due);
                end
            end
            prev_done = done_o;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [5];
        logic [31:0] a, b;
        pool[0] = 32'h0; pool[1] = 32'h7FFF_FFFF; pool[2] = 32'h8000_0000;
        pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h0000_0001;

        rst_i = 1'b0; start_i = 1'b0; ALUCtrl_i = 4'b0000; src1_i = 32'h0; src2_i = 32'h0;
        repeat (3) @(negedge clk_i);
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        chk("rst_flags", {28'h0, busy_o, done_o, overflow_o, illegal_o}, 32'h0);
        rst_i = 1'b1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add_ovf_res", result_o, 32'h8000_0000);
        chk("add_ovf_flag", 32'(overflow_o), 32'd1);
        issue(4'b0110, 32'd5, 32'd5, 1'b0);
        chk("sub_zero", 32'(zero_o), 32'd1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("slt_res", result_o, 32'd1);
        issue(4'b1011, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        chk("lui_res", result_o, 32'h1234_0000);

        issue(4'b1000, 32'hFFFF_FFFF, 32'd3, 1'b1);
`ifdef ALU_MUL_EN
        chk("mul_res", result_o, 32'hFFFF_FFFD);
`else
        chk("mul_off_ill", 32'(illegal_o), 32'd1);
        chk("mul_off_res", result_o, 32'h0);
`endif

        // asynchronous reset in the middle of a cycle with non-reset outputs
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_result", result_o, 32'h0);
        chk("arst_zero", 32'(zero_o), 32'd1);
        chk("arst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

`ifdef ALU_MUL_EN
        // reset at cycle 10 of a MUL: no done may follow
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = 4'b1000; src1_i = 32'd7; src2_i = 32'd9;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("mid_mul_busy", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_mul_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_mul_rst_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
`endif

        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        chk("ill_flag", 32'(illegal_o), 32'd1);
        chk("ill_res", result_o, 32'h0);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            issue(4'($urandom_range(0, 15)), a, b, 1'b0);
        end

        repeat (5) @(negedge clk_i);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
